// File: rtl/dark_window_ctrl.sv
// 3x3 windowed-minimum sequencer for the dark-channel stage: two-line window buffer, border handling, valid/ready both sides.
// Optional macro DCW_ZERO_PAD_EN: out-of-image taps read as 8'h00 instead of replicating the nearest edge pixel.
module dark_window_ctrl #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_sof,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_sof,
  output logic       m_eol,
  output logic       busy,
  output logic       err
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int SR_LEN = 2 * IMG_W + 2;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] inCol_q, outCol_q;
  logic [RW-1:0] inRow_q, outRow_q;
  logic          flushDone_q;
  logic          mValid_q, mSof_q, mEol_q, err_q;
  logic [7:0]    mData_q;
  logic [7:0]    sr_q [SR_LEN];

  logic          slotFree, accept, produce, shiftEn, fillDone, lastIn, lastOut;
  logic [7:0]    newPix, winMin;
  logic [7:0]    win [SR_LEN+1];
  logic [7:0]    tap [3][3];
  logic [7:0]    sel [3][3];
  logic          atTop, atBot, atLeft, atRight;

  assign slotFree = !mValid_q || m_ready;
  assign s_ready  = !rst && ((state_q == ST_IDLE) || (state_q == ST_FILL) ||
                             ((state_q == ST_RUN) && slotFree));
  assign accept   = s_valid && s_ready;
  assign fillDone = (inRow_q == RW'(1)) && (inCol_q == CW'(1));
  assign lastIn   = (inRow_q == LAST_ROW) && (inCol_q == LAST_COL);
  assign lastOut  = (outRow_q == LAST_ROW) && (outCol_q == LAST_COL);
  assign produce  = (accept && ((state_q == ST_RUN) || ((state_q == ST_FILL) && fillDone))) ||
                    ((state_q == ST_FLUSH) && slotFree && !flushDone_q);
  // During FLUSH the window keeps sliding over a virtual pixel that the clamping never selects
  assign newPix   = (state_q == ST_FLUSH) ? 8'h00 : s_data;
  assign shiftEn  = accept || ((state_q == ST_FLUSH) && produce);

  assign atTop   = (outRow_q == '0);
  assign atBot   = (outRow_q == LAST_ROW);
  assign atLeft  = (outCol_q == '0);
  assign atRight = (outCol_q == LAST_COL);

  // win[0] is the pixel arriving now; win[k] is the pixel accepted k transfers ago
  always_comb begin
    win[0] = newPix;
    for (int k = 1; k <= SR_LEN; k++) win[k] = sr_q[k-1];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        tap[i][j] = win[(2 - i) * IMG_W + (2 - j)];
  end

  always_comb begin
    int ri, cj;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ri = i;
        cj = j;
        if ((i == 0 && atTop) || (i == 2 && atBot)) ri = 1;
        if ((j == 0 && atLeft) || (j == 2 && atRight)) cj = 1;
`ifdef DCW_ZERO_PAD_EN
        sel[i][j] = ((ri != i) || (cj != j)) ? 8'h00 : tap[i][j];
`else
        sel[i][j] = tap[ri][cj];
`endif
      end
    end
  end

  always_comb begin
    winMin = 8'hFF;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (sel[i][j] < winMin) winMin = sel[i][j];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && s_sof) state_d = ST_FILL;
      ST_FILL:  if (accept && fillDone) state_d = ST_RUN;
      ST_RUN:   if (accept && lastIn) state_d = ST_FLUSH;
      ST_FLUSH: if (flushDone_q && mValid_q && m_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Window storage is never reset; the frame prefill overwrites everything the clamped taps can reach
  always_ff @(posedge clk) begin
    if (shiftEn) begin
      sr_q[0] <= newPix;
      for (int k = 1; k < SR_LEN; k++) sr_q[k] <= sr_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      inCol_q     <= '0;
      inRow_q     <= '0;
      outCol_q    <= '0;
      outRow_q    <= '0;
      flushDone_q <= 1'b0;
      mValid_q    <= 1'b0;
      mData_q     <= 8'h00;
      mSof_q      <= 1'b0;
      mEol_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (state_q == ST_IDLE) begin
          if (s_sof) begin
            inCol_q     <= CW'(1);
            inRow_q     <= '0;
            outCol_q    <= '0;
            outRow_q    <= '0;
            flushDone_q <= 1'b0;
          end
        end else begin
          if (s_sof) err_q <= 1'b1;
          if (inCol_q == LAST_COL) begin
            inCol_q <= '0;
            inRow_q <= inRow_q + RW'(1);
          end else begin
            inCol_q <= inCol_q + CW'(1);
          end
        end
      end
      if (produce) begin
        mValid_q <= 1'b1;
        mData_q  <= winMin;
        mSof_q   <= atTop && atLeft;
        mEol_q   <= atRight;
        if ((state_q == ST_FLUSH) && lastOut) flushDone_q <= 1'b1;
        if (atRight) begin
          outCol_q <= '0;
          outRow_q <= outRow_q + RW'(1);
        end else begin
          outCol_q <= outCol_q + CW'(1);
        end
      end else if (m_ready) begin
        mValid_q <= 1'b0;
      end
    end
  end

  assign m_valid = mValid_q;
  assign m_data  = mData_q;
  assign m_sof   = mSof_q;
  assign m_eol   = mEol_q;
  assign busy    = (state_q != ST_IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_dark_window_ctrl.sv
// Self-checking bench for dark_window_ctrl on a 4x3 image; the reference computes each 3x3 minimum directly from the frame array.
// Build with +define+DCW_ZERO_PAD_EN to check the zero-padding variant.
module tb_dark_window_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, m_valid, m_sof, m_eol, busy, err;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  dark_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .busy(busy), .err(err)
  );

  int compared = 0;
  int mismatched = 0;

  logic [7:0] expData[$];
  logic       expSof[$];
  logic       expEol[$];
  logic [7:0] streamPix[$];
  logic       streamSof[$];

  logic       prevValid = 1'b0, prevReady = 1'b1;
  logic [7:0] prevData = 8'h00;
  logic       inX, outX, oSof, oEol;
  logic [7:0] oData;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: minimum over the clamped 3x3 neighbourhood, or 0 on the border when zero padding is on
  function automatic logic [7:0] refOut(input logic [7:0] f[N], input int r, input int c);
    int m, rr, cc;
    m = 255;
`ifdef DCW_ZERO_PAD_EN
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'h00;
`endif
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = (r + dr < 0) ? 0 : ((r + dr > H-1) ? H-1 : r + dr);
        cc = (c + dc < 0) ? 0 : ((c + dc > W-1) ? W-1 : c + dc);
        if (int'(f[rr*W + cc]) < m) m = int'(f[rr*W + cc]);
      end
    end
    return 8'(m);
  endfunction

  task automatic addFrame(input logic [7:0] f[N], input int extraSof);
    for (int i = 0; i < N; i++) begin
      streamPix.push_back(f[i]);
      streamSof.push_back(i == 0 || i == extraSof);
    end
    for (int i = 0; i < N; i++) begin
      expData.push_back(refOut(f, i / W, i % W));
      expSof.push_back(i == 0);
      expEol.push_back((i % W) == W-1);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [7:0] sd, input logic ss, input logic mr);
    @(negedge clk);
    if (prevValid && !prevReady) begin
      checkOutput("hold_valid", m_valid, 1);
      checkOutput("hold_data", m_data, prevData);
    end
    s_valid = sv;
    s_data  = sd;
    s_sof   = ss;
    m_ready = mr;
    #1;
    inX       = s_valid && s_ready;
    outX      = m_valid && m_ready;
    oData     = m_data;
    oSof      = m_sof;
    oEol      = m_eol;
    prevValid = m_valid;
    prevReady = m_ready;
    prevData  = m_data;
    @(posedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    m_ready = 1'b1;
    #1;
    checkOutput("rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_sof", m_sof, 0);
    checkOutput("rst_m_eol", m_eol, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_s_ready_after", s_ready, 1);
    prevValid = 1'b0;
    prevReady = 1'b1;
  endtask

  task automatic runStream(input string tag, input int validPct, input int readyPct);
    int cyc, p;
    logic sv;
    cyc = 0;
    p = 0;
    while ((p < streamPix.size() || expData.size() > 0) && cyc < BUDGET) begin
      sv = (p < streamPix.size()) && ($urandom_range(99) < validPct);
      applyStimulus(sv, sv ? streamPix[p] : 8'($urandom), sv ? streamSof[p] : 1'b0,
                    $urandom_range(99) < readyPct);
      if (inX) p++;
      if (outX) begin
        if (expData.size() == 0) begin
          checkOutput({tag, "_extra_out"}, 1, 0);
        end else begin
          checkOutput({tag, "_data"}, oData, expData.pop_front());
          checkOutput({tag, "_sof"}, oSof, expSof.pop_front());
          checkOutput({tag, "_eol"}, oEol, expEol.pop_front());
        end
      end
      cyc++;
    end
    checkOutput({tag, "_timeout"}, cyc < BUDGET, 1);
    streamPix.delete();
    streamSof.delete();
    expData.delete();
    expSof.delete();
    expEol.delete();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput({tag, "_quiet_out"}, outX, 0);
      checkOutput({tag, "_idle_busy"}, busy, 0);
    end
  endtask

  initial begin
    logic [7:0] ramp [N];
    logic [7:0] rnd  [N];
    for (int i = 0; i < N; i++) ramp[i] = 8'(100 + i);

    doReset();

    // Ramp frame at full throughput
    addFrame(ramp, -1);
    runStream("ramp", 100, 100);

    // Same ramp with random gaps and backpressure
    addFrame(ramp, -1);
    runStream("ramp_bp", 60, 50);

    // Random pixel values, random flow control
    for (int i = 0; i < N; i++) rnd[i] = 8'($urandom);
    addFrame(rnd, -1);
    runStream("rand", 70, 50);

    // Pixels without s_sof in IDLE are dropped
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b1);
      checkOutput("drop_accept", inX, 1);
      checkOutput("drop_no_out", m_valid, 0);
      checkOutput("drop_busy", busy, 0);
    end

    // Two back-to-back frames
    for (int i = 0; i < N; i++) rnd[i] = 8'($urandom);
    addFrame(ramp, -1);
    addFrame(rnd, -1);
    runStream("b2b", 100, 100);
    checkOutput("b2b_err_clear", err, 0);

    // s_sof injected mid-frame sets sticky err without resync
    addFrame(ramp, 5);
    runStream("midsof", 100, 100);
    checkOutput("midsof_err", err, 1);
    addFrame(rnd, -1);
    runStream("after_midsof", 80, 60);
    checkOutput("err_sticky", err, 1);

    // Reset while running, then a clean frame
    doReset();
    begin
      int p;
      int cyc;
      p = 0;
      cyc = 0;
      while (p < 8 && cyc < 100) begin
        applyStimulus(1'b1, ramp[p], p == 0, 1'b1);
        if (inX) p++;
        cyc++;
      end
      checkOutput("midrst_reached_run", busy, 1);
    end
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("midrst_no_out", m_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    addFrame(ramp, -1);
    runStream("post_rst", 100, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
